ram32x4_access_ctrl: RTL and testbench
======================================

RAM32X4_ACCESS_CTRL -- requirements
Module: ram32x4_access_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, which sets the number of clk cycles per scan step (1 Hz at 50 MHz).
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port sw_addr, input, 5 bits: manual address from switches.
REQ-005 The block SHALL have port sw_data, input, 4 bits: manual write data from switches.
REQ-006 The block SHALL have port key_write_n, input, 1 bit: active-low pushbutton that requests a single-word write.
REQ-007 The block SHALL have port key_fill_n, input, 1 bit: active-low pushbutton that requests a fill of all 32 words.
REQ-008 The block SHALL have port key_scan_n, input, 1 bit: active-low pushbutton that toggles auto-scan.
REQ-009 The block SHALL have port ram_address, output, 5 bits: address to the 32x4 RAM.
REQ-010 The block SHALL have port ram_data, output, 4 bits: write data to the RAM.
REQ-011 The block SHALL have port ram_wren, output, 1 bit: RAM write enable.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in WRITE or FILL.
REQ-013 The block SHALL have port state, output, 2 bits: IDLE=0, WRITE=1, FILL=2, SCAN=3.

Function
REQ-014 Each key SHALL pass through a 2-flop synchronizer; a press SHALL be one clk-cycle pulse raised when the synchronized level goes from 1 to 0.
REQ-015 A key held low SHALL generate exactly one press; a new press requires a release first.
REQ-016 ram_address, ram_data, ram_wren, busy and state SHALL all be registered outputs.
REQ-017 In IDLE: ram_address SHALL equal sw_addr and ram_data SHALL equal sw_data, each delayed one cycle, with ram_wren=0.
REQ-018 IDLE transitions: fill press goes to FILL; otherwise write press goes to WRITE; otherwise scan press goes to SCAN. Simultaneous presses resolve with priority fill > write > scan, and lower-priority presses are discarded.
REQ-019 On entry to WRITE, sw_addr and sw_data SHALL be captured. WRITE SHALL last exactly 1 cycle with ram_wren=1 at the captured address and data, then return to IDLE.
REQ-020 On entry to FILL, sw_data SHALL be captured and a 5-bit fill counter cleared to 0.
REQ-021 FILL SHALL last exactly 32 consecutive cycles with ram_wren=1, ram_address=0..31 and ram_data=the captured value, then return to IDLE.
REQ-022 On entry to SCAN, the scan address SHALL be set to 0 and the tick counter cleared.
REQ-023 In SCAN: ram_wren=0 and ram_address=the scan address; the scan address SHALL increment once every TICK_DIV cycles and wrap from 31 to 0.
REQ-024 A scan press while in SCAN SHALL return the block to IDLE; write and fill presses in SCAN SHALL be ignored.
REQ-025 All presses during WRITE or FILL SHALL be ignored and not queued.
REQ-026 Latency: a key sampled low at edge k, following a high sample, SHALL cause the state change and output update at edge k+3.
REQ-027 The tick counter SHALL be wide enough for TICK_DIV, and SHALL wrap to 0 on reaching TICK_DIV-1.

Reset
REQ-028 While resetn=0, regardless of clk, the block SHALL force: state=IDLE, ram_address=0, ram_data=0, ram_wren=0, busy=0, all counters=0, synchronizers=1 (released).
REQ-029 Reset asserted mid-FILL or mid-SCAN SHALL abort the operation immediately, with no further write after deassertion.
REQ-030 After resetn rises, the first press SHALL be recognised only after a released level has been synchronized.

Verification
REQ-031 The bench SHALL cover: sw_addr=5'h13, sw_data=4'hA, key_write_n pulsed low 4 cycles -> exactly one cycle with ram_wren=1, ram_address=19, ram_data=A, and a readback q=A.
REQ-032 The bench SHALL cover: sw_data=4'h5, key_fill_n press -> 32 consecutive wren cycles with addresses 0..31, busy=1 throughout; afterwards all 32 words read 5.
REQ-033 The bench SHALL cover: TICK_DIV=4, key_scan_n press -> ram_address steps 0,1,2,... every 4 cycles and wraps 31->0; a second press returns to state=0.
REQ-034 The bench SHALL cover: key_fill_n and key_write_n falling on the same cycle -> FILL entered and no single WRITE cycle occurs.
REQ-035 The bench SHALL cover: resetn pulsed low during FILL at address 10 -> outputs at reset values asynchronously; words 10..31 unchanged from their pre-fill contents.
REQ-036 The bench SHALL cover: key_write_n held low for 100 cycles -> exactly one write.

Source files
------------

// File: rtl/ram32x4_access_ctrl.sv
// Access controller for a 32x4 RAM: manual single-word write, whole-array fill
// and a slow auto-scan, all driven from three debounced-by-sync pushbuttons.
module ram32x4_access_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] sw_addr,
  input  logic [3:0] sw_data,
  input  logic       key_write_n,
  input  logic       key_fill_n,
  input  logic       key_scan_n,
  output logic [4:0] ram_address,
  output logic [3:0] ram_data,
  output logic       ram_wren,
  output logic       busy,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_SCAN  = 2'd3;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [2:0] keys_n;
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] level_q, level_d;
  logic [2:0] press_q, press_d;
  logic       press_write, press_fill, press_scan;

  logic [1:0]        state_q, state_d;
  logic [4:0]        addr_q, addr_d;
  logic [3:0]        data_q, data_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic [3:0]        fill_data_q, fill_data_d;
  logic [4:0]        fill_cnt_q, fill_cnt_d;
  logic [4:0]        scan_addr_q, scan_addr_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

  assign keys_n = {key_scan_n, key_fill_n, key_write_n};

  // Press pulse is registered so a key change reaches the FSM state three edges later
  always_comb begin
    sync1_d = keys_n;
    sync2_d = sync1_q;
    level_d = sync2_q;
    press_d = level_q & ~sync2_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      level_q <= 3'b111;
      press_q <= 3'b000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press_write = press_q[0];
  assign press_fill  = press_q[1];
  assign press_scan  = press_q[2];

  // Outputs are computed for the next state so every port comes straight from a flop
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wren_d      = 1'b0;
    fill_data_d = fill_data_q;
    fill_cnt_d  = fill_cnt_q;
    scan_addr_d = scan_addr_q;
    tick_cnt_d  = tick_cnt_q;

    case (state_q)
      ST_IDLE: begin
        addr_d = sw_addr;
        data_d = sw_data;
        if (press_fill) begin
          state_d     = ST_FILL;
          fill_data_d = sw_data;
          fill_cnt_d  = 5'd0;
          addr_d      = 5'd0;
          wren_d      = 1'b1;
        end else if (press_write) begin
          state_d = ST_WRITE;
          wren_d  = 1'b1;
        end else if (press_scan) begin
          state_d     = ST_SCAN;
          scan_addr_d = 5'd0;
          tick_cnt_d  = '0;
          addr_d      = 5'd0;
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
        addr_d  = sw_addr;
        data_d  = sw_data;
      end

      ST_FILL: begin
        if (fill_cnt_q == 5'd31) begin
          state_d    = ST_IDLE;
          fill_cnt_d = 5'd0;
          addr_d     = sw_addr;
          data_d     = sw_data;
        end else begin
          fill_cnt_d = fill_cnt_q + 5'd1;
          addr_d     = fill_cnt_q + 5'd1;
          data_d     = fill_data_q;
          wren_d     = 1'b1;
        end
      end

      ST_SCAN: begin
        if (press_scan) begin
          state_d     = ST_IDLE;
          scan_addr_d = 5'd0;
          tick_cnt_d  = '0;
          addr_d      = sw_addr;
          data_d      = sw_data;
        end else if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d  = '0;
          scan_addr_d = scan_addr_q + 5'd1;
          addr_d      = scan_addr_q + 5'd1;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          addr_d     = scan_addr_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        addr_d  = sw_addr;
        data_d  = sw_data;
      end
    endcase

    busy_d = (state_d == ST_WRITE) || (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= 5'd0;
      data_q      <= 4'd0;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
      fill_data_q <= 4'd0;
      fill_cnt_q  <= 5'd0;
      scan_addr_q <= 5'd0;
      tick_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      busy_q      <= busy_d;
      fill_data_q <= fill_data_d;
      fill_cnt_q  <= fill_cnt_d;
      scan_addr_q <= scan_addr_d;
      tick_cnt_q  <= tick_cnt_d;
    end
  end

  assign ram_address = addr_q;
  assign ram_data    = data_q;
  assign ram_wren    = wren_q;
  assign busy        = busy_q;
  assign state       = state_q;

endmodule

// File: tb/tb_ram32x4_access_ctrl.sv
// Directed bench for ram32x4_access_ctrl with a behavioural 32x4 RAM on its
// outputs; every write seen on the port is logged for the checks below.
module tb_ram32x4_access_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] sw_addr;
  logic [3:0] sw_data;
  logic       key_write_n, key_fill_n, key_scan_n;
  logic [4:0] ram_address;
  logic [3:0] ram_data;
  logic       ram_wren, busy;
  logic [1:0] state;

  int assert_count = 0;
  int fail_count   = 0;
  int cycle        = 0;

  logic [3:0] mem [32];
  logic [4:0] wr_addr  [$];
  logic [3:0] wr_data  [$];
  logic       wr_busy  [$];
  logic [1:0] wr_state [$];
  int         wr_cycle [$];

  ram32x4_access_ctrl #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sw_addr     (sw_addr),
    .sw_data     (sw_data),
    .key_write_n (key_write_n),
    .key_fill_n  (key_fill_n),
    .key_scan_n  (key_scan_n),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .busy        (busy),
    .state       (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] addr, input logic [3:0] data,
                               input logic wr_n, input logic fill_n, input logic scan_n);
    sw_addr     = addr;
    sw_data     = data;
    key_write_n = wr_n;
    key_fill_n  = fill_n;
    key_scan_n  = scan_n;
  endtask

  // One clock step; outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (ram_wren) begin
      wr_addr.push_back(ram_address);
      wr_data.push_back(ram_data);
      wr_busy.push_back(busy);
      wr_state.push_back(state);
      wr_cycle.push_back(cycle);
    end
  endtask

  task automatic clearLog();
    wr_addr.delete();
    wr_data.delete();
    wr_busy.delete();
    wr_state.delete();
    wr_cycle.delete();
  endtask

  initial begin
    int start;
    int bad_addr, bad_data, bad_busy, bad_state, bad_mem, write_states;

    resetn = 1'b0;
    applyStimulus(5'h00, 4'h0, 1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    checkOutput("rst_state", 32'(state), 0);
    checkOutput("rst_addr", 32'(ram_address), 0);
    checkOutput("rst_data", 32'(ram_data), 0);
    checkOutput("rst_wren", 32'(ram_wren), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    resetn = 1'b1;
    repeat (3) tick();

    // Single write at 0x13 with key held low four cycles
    applyStimulus(5'h13, 4'hA, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    checkOutput("idle_addr", 32'(ram_address), 32'h13);
    checkOutput("idle_data", 32'(ram_data), 32'hA);
    checkOutput("idle_wren", 32'(ram_wren), 0);
    clearLog();
    start = cycle;
    applyStimulus(5'h13, 4'hA, 1'b0, 1'b1, 1'b1);
    repeat (4) tick();
    applyStimulus(5'h13, 4'hA, 1'b1, 1'b1, 1'b1);
    repeat (10) tick();
    checkOutput("write_count", 32'(wr_addr.size()), 1);
    if (wr_addr.size() > 0) begin
      checkOutput("write_addr", 32'(wr_addr[0]), 32'h13);
      checkOutput("write_data", 32'(wr_data[0]), 32'hA);
      checkOutput("write_state", 32'(wr_state[0]), 1);
      checkOutput("write_busy", 32'(wr_busy[0]), 1);
      checkOutput("write_latency", 32'(wr_cycle[0] - start), 4);
    end
    checkOutput("write_readback", 32'(mem[19]), 32'hA);
    checkOutput("write_done_state", 32'(state), 0);

    // Fill all words with 5
    clearLog();
    applyStimulus(5'h00, 4'h5, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    applyStimulus(5'h00, 4'h5, 1'b1, 1'b1, 1'b1);
    repeat (45) tick();
    checkOutput("fill_count", 32'(wr_addr.size()), 32);
    bad_addr = 0; bad_data = 0; bad_busy = 0; bad_state = 0;
    for (int i = 0; i < wr_addr.size(); i++) begin
      if (wr_addr[i] != 5'(i)) bad_addr++;
      if (wr_data[i] != 4'h5) bad_data++;
      if (wr_busy[i] != 1'b1) bad_busy++;
      if (wr_state[i] != 2'd2) bad_state++;
    end
    checkOutput("fill_addr_seq", 32'(bad_addr), 0);
    checkOutput("fill_data", 32'(bad_data), 0);
    checkOutput("fill_busy", 32'(bad_busy), 0);
    checkOutput("fill_state", 32'(bad_state), 0);
    if (wr_cycle.size() == 32) checkOutput("fill_consecutive", 32'(wr_cycle[31] - wr_cycle[0]), 31);
    bad_mem = 0;
    for (int i = 0; i < 32; i++) if (mem[i] != 4'h5) bad_mem++;
    checkOutput("fill_readback", 32'(bad_mem), 0);
    checkOutput("fill_done_busy", 32'(busy), 0);

    // Auto-scan, with a write press that must be ignored
    clearLog();
    applyStimulus(5'h07, 4'h3, 1'b1, 1'b1, 1'b0);
    tick(); tick();
    applyStimulus(5'h07, 4'h3, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 10 && state != 2'd3; n++) tick();
    checkOutput("scan_enter", 32'(state), 3);
    checkOutput("scan_addr_0", 32'(ram_address), 0);
    bad_addr = 0;
    for (int i = 1; i < 136; i++) begin
      if (i == 20) applyStimulus(5'h07, 4'h3, 1'b0, 1'b1, 1'b1);
      if (i == 24) applyStimulus(5'h07, 4'h3, 1'b1, 1'b1, 1'b1);
      tick();
      if (ram_address != 5'((i / 4) % 32) || state != 2'd3) bad_addr++;
    end
    checkOutput("scan_addr_seq", 32'(bad_addr), 0);
    checkOutput("scan_wrapped_addr", 32'(ram_address), 1);
    checkOutput("scan_no_writes", 32'(wr_addr.size()), 0);
    applyStimulus(5'h07, 4'h3, 1'b1, 1'b1, 1'b0);
    tick(); tick();
    applyStimulus(5'h07, 4'h3, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 10 && state != 2'd0; n++) tick();
    checkOutput("scan_exit", 32'(state), 0);
    tick();
    checkOutput("scan_exit_addr", 32'(ram_address), 7);

    // Fill and write pressed together: fill wins, no single write
    clearLog();
    applyStimulus(5'h02, 4'h7, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    applyStimulus(5'h02, 4'h7, 1'b1, 1'b1, 1'b1);
    repeat (45) tick();
    write_states = 0;
    for (int i = 0; i < wr_state.size(); i++) if (wr_state[i] == 2'd1) write_states++;
    checkOutput("both_count", 32'(wr_addr.size()), 32);
    checkOutput("both_no_write", 32'(write_states), 0);
    if (wr_state.size() > 0) checkOutput("both_first_state", 32'(wr_state[0]), 2);
    checkOutput("both_end_state", 32'(state), 0);

    // Reset while filling with C at address 10
    applyStimulus(5'h00, 4'hC, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    applyStimulus(5'h00, 4'hC, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 60 && !(state == 2'd2 && ram_address == 5'd10); n++) tick();
    checkOutput("abort_at_10", 32'(ram_address), 10);
    resetn = 1'b0;
    #1;
    checkOutput("abort_state", 32'(state), 0);
    checkOutput("abort_addr", 32'(ram_address), 0);
    checkOutput("abort_data", 32'(ram_data), 0);
    checkOutput("abort_wren", 32'(ram_wren), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    repeat (3) tick();
    resetn = 1'b1;
    clearLog();
    repeat (40) tick();
    checkOutput("abort_no_writes", 32'(wr_addr.size()), 0);
    bad_mem = 0;
    for (int i = 0; i < 32; i++) if (mem[i] != ((i < 10) ? 4'hC : 4'h7)) bad_mem++;
    checkOutput("abort_mem", 32'(bad_mem), 0);

    // Write key held low for 100 cycles
    clearLog();
    applyStimulus(5'h03, 4'h9, 1'b0, 1'b1, 1'b1);
    repeat (100) tick();
    applyStimulus(5'h03, 4'h9, 1'b1, 1'b1, 1'b1);
    repeat (10) tick();
    checkOutput("hold_count", 32'(wr_addr.size()), 1);
    if (wr_addr.size() > 0) begin
      checkOutput("hold_addr", 32'(wr_addr[0]), 3);
      checkOutput("hold_data", 32'(wr_data[0]), 9);
    end
    checkOutput("hold_readback", 32'(mem[3]), 9);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
